ram2_arbiter: RTL and testbench
===============================

// Module: ram2_arbiter
// PURPOSE
//   Arbitrates the single RAM2 access engine between the instruction-fetch (IF)
//   and execute (EXE, load/store) pipeline stages. Grants one transaction at a
//   time and latches its address and data. Returns read data and a one-cycle
//   done pulse to the winner, and raises a pipeline stall while work is unserved.
//   Sits between the pipeline stages and the RAM2 SRAM sequencer.
// PARAMETERS
//   ADDR_W      18   address width, matches the RAM2 address bus
//   DATA_W      16   data width, matches the RAM2 data bus
//   STARVE_MAX  4    EXE wins in a row with IF waiting before IF is forced to win
//   TIMEOUT     64   max cycles in ISSUE waiting for mem_ack before ERROR
// PORTS
//   clk        in   1       single clock, all state changes on rising edge
//   rst        in   1       asynchronous, active-high reset
//   if_req     in   1       IF fetch request; held until if_done
//   if_addr    in   ADDR_W  fetch address
//   if_done    out  1       one-cycle pulse: fetch complete, if_rdata valid
//   if_rdata   out  DATA_W  fetched word; holds until next IF completion
//   exe_req    in   1       EXE request; held until exe_done
//   exe_we     in   1       1 = store, 0 = load
//   exe_addr   in   ADDR_W  load/store address
//   exe_wdata  in   DATA_W  store data
//   exe_done   out  1       one-cycle pulse: EXE transaction complete
//   exe_rdata  out  DATA_W  load result; holds until next EXE load completion
//   mem_req    out  1       request to RAM2 sequencer; high for whole ISSUE state
//   mem_we     out  1       write strobe for granted transaction
//   mem_addr   out  ADDR_W  latched address, stable while mem_req = 1
//   mem_wdata  out  DATA_W  latched store data, stable while mem_req = 1
//   mem_ack    in   1       sequencer completion pulse; sampled only in ISSUE
//   mem_rdata  in   DATA_W  read data, valid in the cycle mem_ack = 1
//   stall      out  1       (if_req & ~if_done) | (exe_req & ~exe_done), combinational
//   owner      out  2       00 none, 01 IF, 10 EXE (registered)
//   err        out  1       sticky timeout flag
// BEHAVIOUR
//   Reset: state IDLE. All registered outputs are 0, including rdata regs and owner. starve_cnt = 0.
//   States: IDLE -> ISSUE -> RESP -> IDLE. ERROR is absorbing and is left only by rst.
//   IDLE: if any req, pick a winner, latch addr/wdata/we, set owner, go ISSUE.
//     Winner: EXE if exe_req and starve_cnt < STARVE_MAX, else IF if if_req, else EXE.
//     If EXE wins while if_req = 1, starve_cnt increments (saturating).
//     An IF grant clears starve_cnt.
//   ISSUE: mem_req = 1 and the timer counts. When mem_ack = 1, capture mem_rdata
//     into the owner's rdata reg (loads/fetches only) and go RESP.
//     If the timer reaches TIMEOUT, go ERROR, set err = 1 and drop mem_req.
//   RESP: pulse owner's done for exactly 1 cycle, mem_req = 0, owner -> 00, go IDLE.
//   Latency: req seen in cycle 0 -> mem_req at cycle 1 -> ack at cycle k -> done at k+1.
//     Minimum 3 cycles from req to done. At most one access per (ack latency + 3) cycles.
//   Req dropped during ISSUE: access completes, a store is still written,
//     done still pulses, read data is still captured.
//   mem_ack outside ISSUE is ignored. A second mem_ack in ISSUE is impossible (state left).
//   Simultaneous if_req and exe_req in IDLE: priority rule above. The loser stays stalled.
//   Store: exe_rdata is not updated. mem_we = 0 for all IF grants.
//   ERROR: stall follows its equation (requesters stay stalled). No done pulses.
//   rst mid-transaction aborts at once. mem_req drops asynchronously with rst.
// TESTING
//   1 Reset, IF read 0x00010 with ack 2 cycles after mem_req, rdata 0xA5A5
//     -> mem_req cycles 1-3, if_done at cycle 4, if_rdata = 0xA5A5.
//   2 EXE store addr 0x00200, wdata 0x1234 -> mem_we = 1, mem_addr/mem_wdata stable
//     through ISSUE, exe_done one pulse, exe_rdata unchanged.
//   3 if_req and exe_req both held high, ack 1 cycle -> EXE wins 4 times, then IF,
//     then EXE; starve_cnt returns to 0 after the IF grant.
//   4 No mem_ack for 64 ISSUE cycles -> err = 1, mem_req = 0, no done, stall stays 1
//     until rst.
//   5 Assert rst during ISSUE -> all outputs 0 immediately. A new IF request after
//     reset completes normally.
//   6 Spurious mem_ack in IDLE and RESP -> ignored, no done pulse, rdata unchanged.

Source files
------------

// File: rtl/ram2_arbiter.sv
// Arbiter granting the single RAM2 access engine to either instruction fetch or
// execute, one transaction at a time, with starvation guard and ack timeout.
module ram2_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              exe_req,
  input  logic              exe_we,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  output logic              exe_done,
  output logic [DATA_W-1:0] exe_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [1:0]        owner,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERROR} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              gnt_exe_q;
  logic              we_q;
  logic [1:0]        owner_q;
  logic [SW-1:0]     starve_q;
  logic [TW-1:0]     timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] exe_rdata_q;
  logic              err_q;
  logic              any_req;
  logic              grant_exe;

  assign any_req = if_req | exe_req;
  // EXE has priority until IF has been passed over STARVE_MAX times in a row.
  assign grant_exe = (exe_req && (starve_q < STARVE_LIM)) || !if_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE: begin
        if (mem_ack)                   state_d = RESP;
        else if (timer_q == TIMER_LAST) state_d = ERROR;
      end
      RESP:    state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_exe_q   <= 1'b0;
      we_q        <= 1'b0;
      owner_q     <= 2'b00;
      starve_q    <= '0;
      timer_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      exe_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_exe_q <= grant_exe;
            owner_q   <= grant_exe ? 2'b10 : 2'b01;
            addr_q    <= grant_exe ? exe_addr : if_addr;
            wdata_q   <= exe_wdata;
            we_q      <= grant_exe & exe_we;
            timer_q   <= '0;
            if (!grant_exe)
              starve_q <= '0;
            else if (if_req && (starve_q < STARVE_LIM))
              starve_q <= starve_q + 1'b1;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            if (!we_q) begin
              if (gnt_exe_q) exe_rdata_q <= mem_rdata;
              else           if_rdata_q  <= mem_rdata;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
            if (timer_q == TIMER_LAST) err_q <= 1'b1;
          end
        end
        RESP:    owner_q <= 2'b00;
        default: ;
      endcase
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = (state_q == RESP) & ~gnt_exe_q;
  assign exe_done  = (state_q == RESP) & gnt_exe_q;
  assign if_rdata  = if_rdata_q;
  assign exe_rdata = exe_rdata_q;
  assign owner     = owner_q;
  assign err       = err_q;
  assign stall     = (if_req & ~if_done) | (exe_req & ~exe_done);

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed plus randomized bench for ram2_arbiter against a transaction-level
// model of the grant rules, response timing and read-data capture.
module tb_ram2_arbiter;

  localparam int SMAX = 4;

  logic        clk, rst;
  logic        if_req, exe_req, exe_we, mem_ack;
  logic [17:0] if_addr, exe_addr;
  logic [15:0] exe_wdata, mem_rdata;
  logic        if_done, exe_done, mem_req, mem_we, stall, err;
  logic [15:0] if_rdata, exe_rdata, mem_wdata;
  logic [17:0] mem_addr;
  logic [1:0]  owner;

  int          n_vec = 0;
  int          n_err = 0;
  int          starve;
  bit          w_exe;
  logic [1:0]  last_owner;
  logic [15:0] exp_if_rd, exp_exe_rd;

  ram2_arbiter #(.ADDR_W(18), .DATA_W(16), .STARVE_MAX(SMAX), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .exe_req(exe_req), .exe_we(exe_we), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
    .exe_done(exe_done), .exe_rdata(exe_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .owner(owner), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_req"}, mem_req, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
    chk({pfx, "_owner"}, owner, 0);
    chk({pfx, "_if_done"}, if_done, 0);
    chk({pfx, "_exe_done"}, exe_done, 0);
    chk({pfx, "_if_rdata"}, if_rdata, 0);
    chk({pfx, "_exe_rdata"}, exe_rdata, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_stall"}, stall, 0);
  endtask

  // Asserts reset at the current time, checks the immediate effect, releases after an edge.
  task automatic do_reset();
    if_req = 0; exe_req = 0; mem_ack = 0;
    rst = 1;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_owner", owner, 0);
    @(posedge clk); #1;
    chk_zero("rst");
    rst = 0;
    starve = 0;
    exp_if_rd = 0;
    exp_exe_rd = 0;
  endtask

  // Called at the start of an IDLE cycle with requests already driven.
  task automatic run_txn(input int ack_lat, input logic [15:0] rd, input bit drop_early,
                         input bit ack_in_resp, input bit hold_after);
    logic [17:0] ea;
    logic [15:0] ewd;
    bit          ewe;
    #1;
    chk("idle_stall", stall, if_req | exe_req);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_owner", owner, 0);
    w_exe = (exe_req && starve < SMAX) || !if_req;
    if (!w_exe) starve = 0;
    else if (if_req && starve < SMAX) starve++;
    ea  = w_exe ? exe_addr : if_addr;
    ewe = w_exe && exe_we;
    ewd = exe_wdata;
    for (int i = 0; i <= ack_lat; i++) begin
      @(posedge clk); #1;
      if (i == 0) last_owner = owner;
      chk("iss_mem_req", mem_req, 1);
      chk("iss_owner", owner, w_exe ? 2'b10 : 2'b01);
      chk("iss_mem_addr", mem_addr, ea);
      chk("iss_mem_we", mem_we, ewe);
      if (ewe) chk("iss_mem_wdata", mem_wdata, ewd);
      chk("iss_done", {if_done, exe_done}, 0);
      if (i == 0 && drop_early) begin
        if (w_exe) exe_req = 0; else if_req = 0;
      end
      mem_ack   = (i == ack_lat);
      mem_rdata = (i == ack_lat) ? rd : 16'($urandom);
      #1;
      chk("iss_stall", stall, if_req | exe_req);
    end
    @(posedge clk); #1;
    if (!ewe) begin
      if (w_exe) exp_exe_rd = rd; else exp_if_rd = rd;
    end
    chk("resp_if_done", if_done, !w_exe);
    chk("resp_exe_done", exe_done, w_exe);
    chk("resp_mem_req", mem_req, 0);
    chk("resp_mem_we", mem_we, 0);
    chk("resp_if_rdata", if_rdata, exp_if_rd);
    chk("resp_exe_rdata", exe_rdata, exp_exe_rd);
    chk("resp_stall", stall, (if_req & w_exe) | (exe_req & !w_exe));
    mem_ack   = ack_in_resp;
    mem_rdata = 16'($urandom);
    if (hold_after) begin
      if (w_exe) begin
        exe_addr = 18'($urandom); exe_wdata = 16'($urandom);
      end else begin
        if_addr = 18'($urandom);
      end
    end else begin
      if (w_exe) exe_req = 0; else if_req = 0;
    end
    @(posedge clk); #1;
    mem_ack = 0;
    chk("post_done", {if_done, exe_done}, 0);
    chk("post_mem_req", mem_req, 0);
    chk("post_owner", owner, 0);
    chk("post_if_rdata", if_rdata, exp_if_rd);
    chk("post_exe_rdata", exe_rdata, exp_exe_rd);
  endtask

  initial begin
    bit exp_seq [6];
    exp_seq = '{1, 1, 1, 1, 0, 1};
    if_req = 0; exe_req = 0; exe_we = 0; mem_ack = 0;
    if_addr = 0; exe_addr = 0; exe_wdata = 0; mem_rdata = 0;
    rst = 1;
    @(posedge clk); #1;
    do_reset();

    // Basic IF fetch, ack two cycles after mem_req.
    if_req = 1; if_addr = 18'h00010;
    run_txn(2, 16'hA5A5, 0, 0, 0);
    chk("t1_if_rdata", if_rdata, 16'hA5A5);

    // EXE load then store: the store must leave exe_rdata alone.
    exe_req = 1; exe_we = 0; exe_addr = 18'h00300;
    run_txn(1, 16'h5A5A, 0, 0, 0);
    exe_req = 1; exe_we = 1; exe_addr = 18'h00200; exe_wdata = 16'h1234;
    run_txn(3, 16'hFFFF, 0, 0, 0);
    chk("t2_exe_rdata", exe_rdata, 16'h5A5A);

    // Both held: starvation guard lets IF in after four EXE wins.
    if_req = 1; if_addr = 18'h00040;
    exe_req = 1; exe_we = 0; exe_addr = 18'h00080;
    for (int k = 0; k < 6; k++) begin
      run_txn(1, 16'($urandom), 0, 0, 1);
      chk("t3_arb_seq", last_owner, exp_seq[k] ? 2'b10 : 2'b01);
    end
    if_req = 0; exe_req = 0;

    // Randomized traffic with spurious acks and early request drops.
    for (int n = 0; n < 60; n++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = 18'($urandom);
      end
      if (!exe_req && $urandom_range(0, 1) == 1) begin
        exe_req = 1; exe_we = 1'($urandom); exe_addr = 18'($urandom);
        exe_wdata = 16'($urandom);
      end
      if (!if_req && !exe_req) begin
        mem_ack = 1; mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        mem_ack = 0;
        chk("spur_done", {if_done, exe_done}, 0);
        chk("spur_mem_req", mem_req, 0);
        chk("spur_if_rdata", if_rdata, exp_if_rd);
        chk("spur_exe_rdata", exe_rdata, exp_exe_rd);
      end else begin
        run_txn($urandom_range(0, 5), 16'($urandom), ($urandom_range(0, 3) == 0),
                1'($urandom), 0);
      end
    end

    // Timeout: no ack ever arrives.
    do_reset();
    exe_req = 1; exe_we = 0; exe_addr = 18'h00777;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      chk("to_mem_req", mem_req, 1);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("to_err", err, 1);
      chk("to_mem_req_low", mem_req, 0);
      chk("to_done", {if_done, exe_done}, 0);
      chk("to_stall", stall, 1);
      chk("to_exe_rdata", exe_rdata, 0);
      mem_ack = 1; mem_rdata = 16'hBEEF;
    end
    mem_ack = 0;

    // Reset during ISSUE aborts at once; a new fetch then completes.
    do_reset();
    if_req = 1; if_addr = 18'h01234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmid_mem_req", mem_req, 1);
    do_reset();
    if_req = 1; if_addr = 18'h00020;
    run_txn(0, 16'hC3C3, 0, 1, 0);
    chk("rmid_if_rdata", if_rdata, 16'hC3C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
